dino_jump_ctrl: RTL
===================

// Module: dino_jump_ctrl
// PURPOSE
//  Vertical-motion controller for the dino; sits directly upstream of the sprite-select FSM.
//  Turns jump/duck buttons into a registered height above ground plus the airborne, on_ground and is_duck flags.
//  Integer ballistic model (velocity, gravity) advanced once per frame_tick; freezes while is_dead.
// PARAMETERS
//  H_W        10  height width, unsigned px above ground (0 = ground)
//  V_W         6  velocity width, signed px/tick
//  JUMP_VEL   12  launch velocity, px/tick (> 0, < 2^(V_W-1))
//  GRAVITY     1  velocity decrement per tick (> 0)
//  FAST_VEL    6  minimum downward speed under fast-fall (only with DINO_FAST_FALL_EN)
// PORTS
//  clk         in   1    system clock
//  rst         in   1    reset: synchronous, active-high
//  frame_tick  in   1    1-cycle strobe; physics advances only on cycles where it is high
//  jump_btn    in   1    debounced jump button, level
//  duck_btn    in   1    debounced duck button, level
//  is_dead     in   1    game-over; freezes the block
//  height      out  H_W  registered height above ground
//  airborne    out  1    state is RISE or FALL
//  on_ground   out  1    state is GROUND
//  is_duck     out  1    duck_btn held while GROUND, sampled at the last tick
//  jump_start  out  1    1-cycle pulse on the launch tick
// BEHAVIOUR
//  Reset: state=GROUND, height=0, vel=0, on_ground=1, airborne=0, is_duck=0, jump_start=0, jump_req=0.
//  Reset mid-jump snaps to ground the next cycle.
//  Jump request: rising edge of jump_btn (vs. prev-cycle sample) sets sticky jump_req; it is consumed/cleared on the next frame_tick.
//  States: GROUND, RISE, FALL. All updates occur only on frame_tick=1 && !is_dead; outputs are visible the following cycle.
//  GROUND + jump_req -> RISE: vel=JUMP_VEL, height stays 0, jump_start=1, is_duck=0.
//    Jump wins over a held duck_btn.
//  GROUND, no req: is_duck<=duck_btn.
//  RISE/FALL tick: compute s = height + vel in signed (H_W+2) bits.
//    If s <= 0: land -> height=0, vel=0, state=GROUND.
//    Else: height = min(s, 2^H_W-1) (saturate), vel = vel-GRAVITY (clamped at -(2^(V_W-1))).
//    Then state = FALL if the new vel <= 0, else RISE.
//  jump_req arriving while airborne is discarded at the tick (no buffering, no double jump).
//  is_dead=1: all state, height and vel hold; jump_req is cleared; jump_start=0.
//    Physics resumes from the frozen point when is_dead drops.
//  Simultaneous: a jump edge on the same cycle as frame_tick is seen at that tick; rst overrides everything.
//  on_ground and airborne are mutually exclusive and registered; never both 0.
// CONFIGURATION
//  DINO_FAST_FALL_EN defined: in RISE/FALL, duck_btn held at a tick forces vel=min(vel-GRAVITY, -FAST_VEL) and state=FALL.
//    is_duck stays 0 in air.
//  Undefined: duck_btn is ignored while airborne; FAST_VEL is unused.
// STRUCTURE
//  dino_pkg: state enum (GROUND/RISE/FALL), default H_W/V_W widths, signed-sum helper width.
//  One sub-module: btn_edge_latch (prev-sample register, rising-edge detect, sticky request cleared by consume/clear input).
// TESTING (JUMP_VEL=4, GRAVITY=1, H_W=10, fast-fall off unless stated)
//  1 Reset: rst held 2 cycles mid-flight (height=7) -> height=0, on_ground=1, airborne=0, is_duck=0 next cycle.
//  2 Jump arc: one jump edge, then ticks -> launch tick jump_start=1, height 0.
//    Subsequent heights 4,7,9,10,10,9,7,4,0; airborne=1 through the 10s.
//    on_ground=1 after the 0; FALL entered when height first reaches 10.
//  3 Re-jump in air: edge at height 9 -> no effect, identical arc.
//    Edge one cycle before the tick that lands -> ignored; a new edge after landing launches on the next tick.
//  4 Duck: duck_btn held on ground -> is_duck=1 after next tick.
//    Jump edge with duck held -> jump_start=1, is_duck=0, normal arc.
//  5 Death freeze: is_dead at height 9 for 20 ticks -> height stays 9, vel held.
//    Release -> continues 7,4,0; jump edge during freeze is dropped.
//  6 Fast-fall (DINO_FAST_FALL_EN, FAST_VEL=6): duck held from height 7 (vel 2) -> height 1, then land at 0.
//    Without the macro -> normal arc.

Source files
------------

// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dino_pkg
// Description : Shared types and widths for the dino vertical-motion block.
// Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

  // Vertical motion state of the dino
  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } dino_state_t;

  // Default height width (unsigned px above ground)
  localparam int DINO_H_W = 10;
  // Default velocity width (signed px/tick)
  localparam int DINO_V_W = 6;

  // Width of the signed height+velocity sum: one bit for sign, one for carry
  function automatic int sum_width(input int h_w);
    return h_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dino_jump_ctrl_btn_edge_latch.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_latch
// Description : Rising-edge detector with a sticky request. The request is
//               visible combinationally in the cycle of the edge itself, so a
//               consumer sampling on that same cycle sees it.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clear,
  output logic pending
);

  logic btn_prev;
  logic req;
  logic rise;

  assign rise    = btn & ~btn_prev;
  assign pending = req | rise;

  // Track the previous button level and hold a request until it is consumed.
  // During reset the previous sample follows the button so a button held
  // through reset does not look like a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_prev <= btn;
      req      <= 1'b0;
    end else begin
      btn_prev <= btn;
      if (clear) begin
        req <= 1'b0;
      end else if (rise) begin
        req <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_jump_ctrl
// Description : Vertical-motion controller for the dino. Integer ballistic
//               model (launch velocity, gravity) stepped once per frame_tick,
//               frozen while is_dead.
//               Optional feature macro: DINO_FAST_FALL_EN (duck in the air
//               forces a fast descent of at least FAST_VEL px/tick).
// Revision    : 1.0 - initial release
// ============================================================================
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int H_W      = DINO_H_W,
  parameter int V_W      = DINO_V_W,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1
`ifdef DINO_FAST_FALL_EN
  ,
  parameter int FAST_VEL = 6
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           jump_btn,
  input  logic           duck_btn,
  input  logic           is_dead,
  output logic [H_W-1:0] height,
  output logic           airborne,
  output logic           on_ground,
  output logic           is_duck,
  output logic           jump_start
);

  localparam int SUM_W = sum_width(H_W);

  localparam logic signed [V_W-1:0]   JUMP_V      = V_W'(JUMP_VEL);
  localparam logic signed [V_W:0]     GRAV_EXT    = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W-1:0]   VEL_MIN     = {1'b1, {(V_W-1){1'b0}}};
  localparam logic signed [V_W:0]     VEL_MIN_EXT = {1'b1, VEL_MIN};
  localparam logic signed [SUM_W-1:0] H_SAT       = {2'b00, {H_W{1'b1}}};
`ifdef DINO_FAST_FALL_EN
  localparam logic signed [V_W-1:0]   FAST_NEG    = V_W'(-FAST_VEL);
`endif

  dino_state_t             state;
  dino_state_t             state_nx;
  logic signed [V_W-1:0]   vel;
  logic signed [V_W-1:0]   vel_nx;
  logic [H_W-1:0]          height_nx;
  logic                    is_duck_nx;
  logic                    jump_start_nx;
  logic                    jump_pending;
  logic                    step;
  logic signed [SUM_W-1:0] sum;
  logic signed [V_W:0]     vel_dec;
  logic signed [V_W-1:0]   vel_air;

  // Jump presses are turned into a sticky request; every tick consumes it,
  // and a freeze discards it.
  btn_edge_latch u_jump_latch (
    .clk     (clk),
    .rst     (rst),
    .btn     (jump_btn),
    .clear   (frame_tick | is_dead),
    .pending (jump_pending)
  );

  assign step = frame_tick & ~is_dead;

  // Next-state and physics: only a live tick changes anything.
  always_comb begin
    state_nx      = state;
    vel_nx        = vel;
    height_nx     = height;
    is_duck_nx    = is_duck;
    jump_start_nx = 1'b0;

    sum     = $signed({2'b00, height}) + $signed({{(SUM_W-V_W){vel[V_W-1]}}, vel});
    vel_dec = $signed({vel[V_W-1], vel}) - GRAV_EXT;
    vel_air = (vel_dec < VEL_MIN_EXT) ? VEL_MIN : vel_dec[V_W-1:0];
`ifdef DINO_FAST_FALL_EN
    if (duck_btn && (vel_air > FAST_NEG)) begin
      vel_air = FAST_NEG;
    end
`endif

    if (step) begin
      case (state)
        ST_GROUND: begin
          if (jump_pending) begin
            // Jump wins over a held duck
            state_nx      = ST_RISE;
            vel_nx        = JUMP_V;
            height_nx     = '0;
            jump_start_nx = 1'b1;
            is_duck_nx    = 1'b0;
          end else begin
            is_duck_nx = duck_btn;
          end
        end
        ST_RISE, ST_FALL: begin
          is_duck_nx = 1'b0;
          if (sum <= 0) begin
            state_nx  = ST_GROUND;
            height_nx = '0;
            vel_nx    = '0;
          end else begin
            height_nx = (sum > H_SAT) ? {H_W{1'b1}} : sum[H_W-1:0];
            vel_nx    = vel_air;
            state_nx  = (vel_air <= 0) ? ST_FALL : ST_RISE;
          end
        end
        default: begin
          state_nx  = ST_GROUND;
          height_nx = '0;
          vel_nx    = '0;
        end
      endcase
    end
  end

  // State, physics and flag registers; the ground/air flags follow next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_GROUND;
      vel        <= '0;
      height     <= '0;
      is_duck    <= 1'b0;
      jump_start <= 1'b0;
      on_ground  <= 1'b1;
      airborne   <= 1'b0;
    end else begin
      state      <= state_nx;
      vel        <= vel_nx;
      height     <= height_nx;
      is_duck    <= is_duck_nx;
      jump_start <= jump_start_nx;
      on_ground  <= (state_nx == ST_GROUND);
      airborne   <= (state_nx != ST_GROUND);
    end
  end

endmodule
`default_nettype wire
